ctrl_frame_transceiver: RTL and testbench

Parametrised successor to the fixed 128-bit/2-lane control package transceiver. It serialises a configurable-width control package MSB-first over a configurable-width lane, enforces a minimum inter-frame gap, and receives DV-framed packages with explicit length checking. Each received frame is compared against the last transmitted snapshot, and an internal loopback mode is provided. It sits between the control register block and the board-level ctrl TX/RX pins, in the sys_clk domain.

---
 rtl/ctrl_frame_transceiver.sv | 192 +++++++++++++++++++
 tb/tb_ctrl_frame_transceiver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_frame_transceiver.sv
// ctrl_frame_transceiver: serialises a PKT_W-bit control package MSB-first over
// a LANE_W-bit lane with a forced idle gap after every frame, and receives
// DV-framed packages with exact-length checking. Each good received frame is
// compared against the last transmitted snapshot. lb_en feeds the receiver
// from the local transmitter instead of the pins.
module ctrl_frame_transceiver #(
   parameter int PKT_W   = 128,
   parameter int LANE_W  = 2,
   parameter int GAP_CYC = 4
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              tx_start,
   input  logic [PKT_W-1:0]  tx_package_i,
   input  logic              lb_en,
   output logic              tx_busy,
   output logic              tx_done,
   output logic [PKT_W-1:0]  rx_package_o,
   output logic              rx_valid,
   output logic              rx_good,
   output logic              rx_err,
   output logic              ctrl_tx_clk,
   output logic              ctrl_rx_clk,
   output logic [LANE_W-1:0] ctrl_tx_data,
   output logic              ctrl_tx_en,
   input  logic [LANE_W-1:0] ctrl_rx_data,
   input  logic              ctrl_rx_dv
);

   localparam int BEATS = PKT_W / LANE_W;
   localparam int CNT_W = $clog2(BEATS + 2);
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BEATS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BEATS + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_e;

   // ---------------- TX side ----------------
   tx_state_e          st_q;
   logic [PKT_W-1:0]   tx_snap_q;   // comparison reference, held between frames
   logic [PKT_W-1:0]   tx_sh_q;     // working copy shifted out MSB-first
   logic [CNT_W-1:0]   beat_q;
   logic [GAP_W-1:0]   gap_q;
   logic               tx_en_q;
   logic [LANE_W-1:0]  tx_data_q;
   logic               tx_done_q;
   logic               tx_busy_q;
   logic               tx_accept;

   assign tx_accept = (st_q == ST_IDLE) && tx_start;

   // TX FSM with registered lane outputs; busy lags the state by one cycle
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= ST_IDLE;
         tx_snap_q <= '0;
         tx_sh_q   <= '0;
         beat_q    <= '0;
         gap_q     <= '0;
         tx_en_q   <= 1'b0;
         tx_data_q <= '0;
         tx_done_q <= 1'b0;
         tx_busy_q <= 1'b0;
      end else begin
         tx_done_q <= 1'b0;
         tx_busy_q <= (st_q != ST_IDLE);
         case (st_q)
            ST_IDLE: begin
               tx_en_q   <= 1'b0;
               tx_data_q <= '0;
               if (tx_start) begin
                  tx_snap_q <= tx_package_i;
                  tx_sh_q   <= tx_package_i;
                  beat_q    <= '0;
                  st_q      <= ST_SEND;
               end
            end
            ST_SEND: begin
               tx_en_q   <= 1'b1;
               tx_data_q <= tx_sh_q[PKT_W-1 -: LANE_W];
               tx_sh_q   <= tx_sh_q << LANE_W;
               if (beat_q == CNT_LAST) begin
                  gap_q <= '0;
                  st_q  <= ST_GAP;
               end else begin
                  beat_q <= beat_q + 1'b1;
               end
            end
            ST_GAP: begin
               tx_en_q   <= 1'b0;
               tx_data_q <= '0;
               tx_done_q <= (gap_q == '0);
               if (gap_q == GAP_LAST) begin
                  st_q <= ST_IDLE;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            default: begin
               st_q    <= ST_IDLE;
               tx_en_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------- RX side ----------------
   logic               rx_dv_s;
   logic [LANE_W-1:0]  rx_data_s;
   logic               rx_dv_q;
   logic [LANE_W-1:0]  rx_data_q;
   logic [PKT_W-1:0]   rx_sh_q, rx_sh_d;
   logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
   logic [PKT_W-1:0]   rx_pkg_q;
   logic               rx_valid_q;
   logic               rx_err_q;
   logic               rx_good_q;
   logic               frame_end;

   assign rx_dv_s   = lb_en ? tx_en_q   : ctrl_rx_dv;
   assign rx_data_s = lb_en ? tx_data_q : ctrl_rx_data;
   assign frame_end = !rx_dv_q && (rx_cnt_q != '0);

   // Input register stage on the selected lane source
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_dv_q   <= 1'b0;
         rx_data_q <= '0;
      end else begin
         rx_dv_q   <= rx_dv_s;
         rx_data_q <= rx_data_s;
      end
   end

   // Shift/count next state; counter saturates so a long frame never wraps to BEATS
   always_comb begin
      rx_sh_d  = rx_sh_q;
      rx_cnt_d = rx_cnt_q;
      if (rx_dv_q) begin
         rx_sh_d = (rx_sh_q << LANE_W) | PKT_W'(rx_data_q);
         if (rx_cnt_q != CNT_MAX) rx_cnt_d = rx_cnt_q + 1'b1;
      end else if (frame_end) begin
         rx_cnt_d = '0;
      end
   end

   // Frame-end evaluation; an accepted tx_start clears rx_good last so it wins
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sh_q    <= '0;
         rx_cnt_q   <= '0;
         rx_pkg_q   <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         rx_good_q  <= 1'b0;
      end else begin
         rx_sh_q    <= rx_sh_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         if (frame_end) begin
            if (rx_cnt_q == CNT_FULL) begin
               rx_pkg_q   <= rx_sh_q;
               rx_valid_q <= 1'b1;
               rx_good_q  <= (rx_sh_q == tx_snap_q);
            end else begin
               rx_err_q  <= 1'b1;
               rx_good_q <= 1'b0;
            end
         end
         if (tx_accept) rx_good_q <= 1'b0;
      end
   end

   assign tx_busy      = tx_busy_q;
   assign tx_done      = tx_done_q;
   assign ctrl_tx_en   = tx_en_q;
   assign ctrl_tx_data = tx_data_q;
   assign ctrl_tx_clk  = sys_clk;
   assign ctrl_rx_clk  = sys_clk;
   assign rx_package_o = rx_pkg_q;
   assign rx_valid     = rx_valid_q;
   assign rx_err       = rx_err_q;
   assign rx_good      = rx_good_q;

endmodule

// File: tb/tb_ctrl_frame_transceiver.sv
// Bench for ctrl_frame_transceiver: a default instance (A, 128/2/4) and a
// narrow instance (B, 32/8/2) checked every cycle against an event-level model
// plus hand-computed literal expectations from the directed tests.
module tb_ctrl_frame_transceiver;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // instance A
   logic         start_a = 1'b0, lb_a = 1'b0, dv_a = 1'b0;
   logic [127:0] pkg_a = '0;
   logic [1:0]   rxd_a = '0;
   logic         busy_a, done_a, valid_a, good_a, err_a, txclk_a, rxclk_a, en_a;
   logic [127:0] rpkg_a;
   logic [1:0]   txd_a;
   // instance B
   logic         start_b = 1'b0, lb_b = 1'b0, dv_b = 1'b0;
   logic [31:0]  pkg_b = '0;
   logic [7:0]   rxd_b = '0;
   logic         busy_b, done_b, valid_b, good_b, err_b, txclk_b, rxclk_b, en_b;
   logic [31:0]  rpkg_b;
   logic [7:0]   txd_b;

   ctrl_frame_transceiver #(.PKT_W(128), .LANE_W(2), .GAP_CYC(4)) dut_a (
      .sys_clk(clk), .rst_n(rst_n), .tx_start(start_a), .tx_package_i(pkg_a), .lb_en(lb_a),
      .tx_busy(busy_a), .tx_done(done_a), .rx_package_o(rpkg_a), .rx_valid(valid_a),
      .rx_good(good_a), .rx_err(err_a), .ctrl_tx_clk(txclk_a), .ctrl_rx_clk(rxclk_a),
      .ctrl_tx_data(txd_a), .ctrl_tx_en(en_a), .ctrl_rx_data(rxd_a), .ctrl_rx_dv(dv_a));

   ctrl_frame_transceiver #(.PKT_W(32), .LANE_W(8), .GAP_CYC(2)) dut_b (
      .sys_clk(clk), .rst_n(rst_n), .tx_start(start_b), .tx_package_i(pkg_b), .lb_en(lb_b),
      .tx_busy(busy_b), .tx_done(done_b), .rx_package_o(rpkg_b), .rx_valid(valid_b),
      .rx_good(good_b), .rx_err(err_b), .ctrl_tx_clk(txclk_b), .ctrl_rx_clk(rxclk_b),
      .ctrl_tx_data(txd_b), .ctrl_tx_en(en_b), .ctrl_rx_data(rxd_b), .ctrl_rx_dv(dv_b));

   localparam int EN = 0, TXD = 1, DONE = 2, VLD = 3, PKG = 4, GOOD = 5, ERR = 6, BUSY = 7;
   localparam int B = 10;

   function automatic int beats_of(int i); return (i == 0) ? 64 : 4; endfunction
   function automatic int lane_of(int i);  return (i == 0) ? 2 : 8;   endfunction
   function automatic int gap_of(int i);   return (i == 0) ? 4 : 2;   endfunction
   function automatic int pkt_of(int i);   return (i == 0) ? 128 : 32; endfunction

   function automatic string sig_nm(int s);
      case (s)
         EN: return "tx_en"; TXD: return "tx_data"; DONE: return "tx_done";
         VLD: return "rx_valid"; PKG: return "rx_package"; GOOD: return "rx_good";
         ERR: return "rx_err"; default: return "tx_busy";
      endcase
   endfunction

   function automatic logic [127:0] outv(int sel);
      case (sel)
         EN: return 128'(en_a);       TXD: return 128'(txd_a);   DONE: return 128'(done_a);
         VLD: return 128'(valid_a);   PKG: return rpkg_a;        GOOD: return 128'(good_a);
         ERR: return 128'(err_a);     BUSY: return 128'(busy_a);
         B+EN: return 128'(en_b);     B+TXD: return 128'(txd_b); B+DONE: return 128'(done_b);
         B+VLD: return 128'(valid_b); B+PKG: return 128'(rpkg_b); B+GOOD: return 128'(good_b);
         B+ERR: return 128'(err_b);   default: return 128'(busy_b);
      endcase
   endfunction

   // ---------------- event-level model ----------------
   int           cyc = 0;
   int           m_acc[2], m_nok[2], m_rxn[2], m_pend[2];
   logic [127:0] m_snap[2], m_pkg[2], m_ppkg[2];
   logic         m_pok[2], m_good[2], m_valid[2], m_err[2], m_en[2], m_done[2], m_busy[2];
   logic [7:0]   m_data[2];
   logic [7:0]   m_rxb[2][128];

   function automatic logic [127:0] mexp(int i, int s);
      case (s)
         EN: return 128'(m_en[i]);      TXD: return 128'(m_data[i]); DONE: return 128'(m_done[i]);
         VLD: return 128'(m_valid[i]);  PKG: return m_pkg[i];        GOOD: return 128'(m_good[i]);
         ERR: return 128'(m_err[i]);    default: return 128'(m_busy[i]);
      endcase
   endfunction

   task automatic m_reset(input int i);
      m_acc[i] = -1000; m_nok[i] = 0; m_rxn[i] = 0; m_pend[i] = -1;
      m_snap[i] = '0; m_pkg[i] = '0; m_ppkg[i] = '0; m_pok[i] = 1'b0;
      m_good[i] = 1'b0; m_valid[i] = 1'b0; m_err[i] = 1'b0;
      m_en[i] = 1'b0; m_done[i] = 1'b0; m_busy[i] = 1'b0; m_data[i] = '0;
   endtask

   // One clock edge: frame results land one edge after the receiver first
   // sees dv low, the compare uses the pre-edge snapshot, acceptance clears good.
   task automatic m_step(input int i, input logic st, input logic [127:0] pkg,
                         input logic lb, input logic pdv, input logic [7:0] pd);
      int b, ln, pk, d;
      logic sdv;
      logic [7:0] sd;
      logic [127:0] t;
      b = beats_of(i); ln = lane_of(i); pk = pkt_of(i);
      sdv = lb ? m_en[i] : pdv;
      sd  = lb ? m_data[i] : pd;
      m_valid[i] = 1'b0; m_err[i] = 1'b0;
      if (m_pend[i] == cyc) begin
         if (m_pok[i]) begin
            m_pkg[i] = m_ppkg[i]; m_valid[i] = 1'b1; m_good[i] = (m_ppkg[i] == m_snap[i]);
         end else begin
            m_err[i] = 1'b1; m_good[i] = 1'b0;
         end
      end
      if (sdv) begin
         if (m_rxn[i] < 128) m_rxb[i][m_rxn[i]] = sd;
         m_rxn[i]++;
      end else if (m_rxn[i] > 0) begin
         m_pend[i] = cyc + 1;
         m_pok[i] = (m_rxn[i] == b);
         t = '0;
         if (m_pok[i])
            for (int j = 0; j < b; j++) t |= 128'(m_rxb[i][j]) << (pk - (j + 1) * ln);
         m_ppkg[i] = t;
         m_rxn[i] = 0;
      end
      if (st && cyc >= m_nok[i]) begin
         m_acc[i] = cyc; m_snap[i] = pkg; m_nok[i] = cyc + b + gap_of(i) + 1; m_good[i] = 1'b0;
      end
      d = cyc - m_acc[i];
      m_en[i]   = (d >= 1) && (d <= b);
      m_done[i] = (d == b + 1);
      m_busy[i] = (d >= 1) && (d <= b + gap_of(i));
      if (m_en[i]) begin
         t = m_snap[i] >> (pk - d * ln);
         m_data[i] = t[7:0] & 8'((1 << ln) - 1);
      end else begin
         m_data[i] = '0;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_reset(0); m_reset(1);
      end else begin
         cyc++;
         m_step(0, start_a, pkg_a, lb_a, dv_a, 8'(rxd_a));
         m_step(1, start_b, 128'(pkg_b), lb_b, dv_b, rxd_b);
      end
   end

   // ---------------- compare process ----------------
   int           n_vec = 0, n_bad = 0;
   string        lit_nm[64];
   int           lit_sel[64];
   logic [127:0] lit_exp[64];
   int           lit_wr = 0, lit_rd = 0;

   task automatic check(input string nm, input logic [127:0] a, input logic [127:0] e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++)
         for (int s = 0; s < 8; s++)
            check($sformatf("%s.%s", (i == 0) ? "A" : "B", sig_nm(s)), outv(i * B + s), mexp(i, s));
      check("clk_out", 128'({txclk_a, rxclk_a, txclk_b, rxclk_b}), 128'({4{clk}}));
      while (lit_rd != lit_wr) begin
         check(lit_nm[lit_rd], outv(lit_sel[lit_rd]), lit_exp[lit_rd]);
         lit_rd++;
      end
   end

   // Literal expectation, checked at the next falling edge
   task automatic lit(input string nm, input int sel, input logic [127:0] v);
      if (lit_wr < 64) begin
         lit_nm[lit_wr] = nm; lit_sel[lit_wr] = sel; lit_exp[lit_wr] = v; lit_wr++;
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   localparam logic [127:0] P1 = 128'hA5B6C7D8_E9FA0B1C_2D3E4F50_61728394;
   localparam logic [127:0] P6 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

   initial begin
      #1 rst_n = 1'b0;
      step();
      lit("rst_en", EN, 0); lit("rst_busy", BUSY, 0); lit("rst_pkg", PKG, 0); lit("rst_good", GOOD, 0);
      step(); step();
      rst_n = 1'b1;
      step(); step();

      // Test 1: loopback, defaults
      lb_a = 1'b1; pkg_a = P1; start_a = 1'b1;
      step();                       // acceptance edge k
      start_a = 1'b0;
      step();                       // k+1
      lit("t1_first_beat", TXD, 2'b10); lit("t1_en", EN, 1);
      repeat (63) step();           // k+64
      lit("t1_last_beat", TXD, 2'b00);
      step();                       // k+65
      lit("t1_done", DONE, 1); lit("t1_en_low", EN, 0);
      repeat (2) step();            // k+67
      lit("t1_valid", VLD, 1); lit("t1_pkg", PKG, P1); lit("t1_good", GOOD, 1);
      repeat (10) step();

      // Test 2: short frame on the pins
      lb_a = 1'b0;
      for (int j = 0; j < 63; j++) begin dv_a = 1'b1; rxd_a = 2'(j); step(); end
      dv_a = 1'b0; rxd_a = '0;
      step();
      lit("t2_err_early", ERR, 0);
      step();
      lit("t2_err", ERR, 1); lit("t2_valid", VLD, 0); lit("t2_pkg", PKG, P1); lit("t2_good", GOOD, 0);
      repeat (5) step();

      // Test 3: long frame, counter saturation must not fake a valid
      for (int j = 0; j < 70; j++) begin dv_a = 1'b1; rxd_a = 2'(j + 1); step(); end
      dv_a = 1'b0; rxd_a = '0;
      repeat (2) step();
      lit("t3_err", ERR, 1); lit("t3_valid", VLD, 0);
      repeat (5) step();

      // Test 4: narrow instance, start held for 10 cycles
      lb_b = 1'b1; pkg_b = 32'hDEADBEEF; start_b = 1'b1;
      step();                       // k
      for (int c = 1; c <= 16; c++) begin
         step();
         if (c == 9) start_b = 1'b0;
         case (c)
            1: lit("t4_beat0", B + TXD, 8'hDE);
            2: lit("t4_beat1", B + TXD, 8'hAD);
            3: lit("t4_beat2", B + TXD, 8'hBE);
            4: lit("t4_beat3", B + TXD, 8'hEF);
            5: lit("t4_done", B + DONE, 1);
            7: begin lit("t4_busy_low", B + BUSY, 0); lit("t4_valid1", B + VLD, 1); lit("t4_good_cleared", B + GOOD, 0); end
            8: begin lit("t4_restart_en", B + EN, 1); lit("t4_restart_beat", B + TXD, 8'hDE); end
            14: begin lit("t4_valid2", B + VLD, 1); lit("t4_good2", B + GOOD, 1); lit("t4_pkg", B + PKG, 32'hDEADBEEF); end
            default: ;
         endcase
      end

      // Test 5: send zeros, receive all ones on the pins
      lb_a = 1'b0; pkg_a = '0; start_a = 1'b1;
      step();
      start_a = 1'b0;
      repeat (70) step();
      for (int j = 0; j < 64; j++) begin dv_a = 1'b1; rxd_a = 2'b11; step(); end
      dv_a = 1'b0; rxd_a = '0;
      repeat (2) step();
      lit("t5_valid", VLD, 1); lit("t5_good", GOOD, 0); lit("t5_pkg", PKG, {128{1'b1}});
      repeat (5) step();

      // Test 6: asynchronous reset in the middle of a loopback frame
      lb_a = 1'b1; pkg_a = P6; start_a = 1'b1;
      step();
      start_a = 1'b0;
      repeat (30) step();
      #1 rst_n = 1'b0;
      lit("t6_en", EN, 0); lit("t6_busy", BUSY, 0); lit("t6_pkg", PKG, 0);
      lit("t6_txd", TXD, 0); lit("t6_pkg_b", B + PKG, 0);
      step(); step();
      rst_n = 1'b1;
      step();
      pkg_a = P6; start_a = 1'b1;
      step();                       // k
      start_a = 1'b0;
      repeat (67) step();           // k+67
      lit("t6_valid", VLD, 1); lit("t6_good", GOOD, 1); lit("t6_err", ERR, 0); lit("t6_pkg_rx", PKG, P6);
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
